// File: rtl/imem_dmem_arbiter.sv
// Shares one single-ported, variable-latency memory between instruction fetch (I)
// and data load/store (D). D has priority; a starvation counter eventually forces I through.
module imem_dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic [DATA_W-1:0] i_rdata_o,
  output logic              i_ack_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_ack_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              owner_o,
  output logic              err_o
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [3:0] SLIM    = 4'(STARVE_LIMIT);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic [7:0]        wait_cnt_q, wait_cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              owner_q, owner_d;
  logic              err_q, err_d;
  logic              grant_i;
  logic              done;
  logic [DATA_W-1:0] rd_val;

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    i_ack_d      = 1'b0;
    d_ack_d      = 1'b0;
    owner_d      = owner_q;
    err_d        = err_q;
    grant_i      = 1'b0;
    done         = 1'b0;
    rd_val       = '0;
    case (state_q)
      IDLE: begin
        if (i_req_i || d_req_i) begin
          grant_i = i_req_i && (!d_req_i || starve_cnt_q == SLIM);
          if (grant_i) begin
            owner_d      = 1'b0;
            mem_we_d     = 1'b0;
            mem_addr_d   = i_addr_i;
            mem_wdata_d  = '0;
            starve_cnt_d = '0;
          end else begin
            owner_d     = 1'b1;
            mem_we_d    = d_we_i;
            mem_addr_d  = d_addr_i;
            mem_wdata_d = d_wdata_i;
            // I only counts as starved when it was actually asking
            if (i_req_i && starve_cnt_q != SLIM) starve_cnt_d = starve_cnt_q + 4'd1;
          end
          mem_req_d  = 1'b1;
          wait_cnt_d = '0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (mem_ack_i) begin
          done   = 1'b1;
          rd_val = mem_we_q ? '0 : mem_rdata_i;
        end else if (wait_cnt_q == TO_LAST) begin
          done  = 1'b1;
          err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
        if (done) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = RESP;
          if (owner_q) begin
            d_rdata_d = rd_val;
            d_ack_d   = 1'b1;
          end else begin
            i_rdata_d = rd_val;
            i_ack_d   = 1'b1;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      wait_cnt_q   <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      i_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      owner_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      i_ack_q      <= i_ack_d;
      d_ack_q      <= d_ack_d;
      owner_q      <= owner_d;
      err_q        <= err_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign i_rdata_o   = i_rdata_q;
  assign d_rdata_o   = d_rdata_q;
  assign i_ack_o     = i_ack_q;
  assign d_ack_o     = d_ack_q;
  assign owner_o     = owner_q;
  assign err_o       = err_q;

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares one single-ported backing memory between the CPU's instruction-fetch side (I) and data load/store side (D).
- Sits between the CPU pipeline's IM/DM request points and a unified, variable-latency memory.
- Serialises accesses, prioritises data over fetch with a starvation guard, and aborts accesses the memory never acknowledges.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
STARVE_LIMIT, 4, consecutive lost I arbitrations before I is forced to win (legal range 1..15)
TIMEOUT, 16, BUSY cycles without mem_ack_i before the access is aborted (legal range 2..255)

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  asynchronous active-low reset
i_req_i  input  1  instruction fetch request
i_addr_i  input  ADDR_W  fetch address
i_rdata_o  output  DATA_W  fetched word, valid while i_ack_o=1
i_ack_o  output  1  one-cycle completion pulse, I side
d_req_i  input  1  data access request
d_we_i  input  1  1=store, 0=load
d_addr_i  input  ADDR_W  data address
d_wdata_i  input  DATA_W  store data
d_rdata_o  output  DATA_W  load data, valid while d_ack_o=1
d_ack_o  output  1  one-cycle completion pulse, D side
mem_req_o  output  1  memory request, held until mem_ack_i
mem_we_o  output  1  memory write enable
mem_addr_o  output  ADDR_W  memory address
mem_wdata_o  output  DATA_W  memory write data
mem_rdata_i  input  DATA_W  memory read data, valid with mem_ack_i
mem_ack_i  input  1  memory completion, one cycle
owner_o  output  1  current/last grant: 0=I, 1=D
err_o  output  1  sticky timeout flag

Behaviour:
- Reset (rst_i=0, any time, including mid-access):
  - State goes to IDLE immediately.
  - All outputs go to 0: mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, both ack_o, both rdata_o, owner_o, err_o.
  - starve_cnt and wait_cnt go to 0.
  - The in-flight access is dropped silently and no ack is issued.
- FSM states: IDLE, BUSY, RESP. All outputs are registered.
- IDLE:
  - Requests are sampled only in this state.
  - No request: stay in IDLE.
  - Otherwise pick a winner, latch addr/we/wdata (we=0, wdata=0 for I), set owner_o, then go to BUSY.
- Arbitration:
  - Only I requesting: I wins. Only D requesting: D wins.
  - Both requesting: D wins unless starve_cnt==STARVE_LIMIT, in which case I wins.
  - starve_cnt increments (saturating at STARVE_LIMIT) when I loses; it clears to 0 when I is granted.
- BUSY:
  - mem_req_o=1, with mem_we_o/mem_addr_o/mem_wdata_o held stable at the latched values.
  - wait_cnt counts cycles in BUSY.
  - mem_ack_i=1: capture mem_rdata_i into the owner's rdata register (all zeros for stores), drop mem_req_o, go to RESP.
  - wait_cnt reaches TIMEOUT-1 with no ack: drop mem_req_o, set err_o=1, load rdata=0, go to RESP.
  - A mem_ack_i arriving after the abort is ignored.
- RESP:
  - Owner's ack_o=1 for exactly one cycle, with rdata_o valid; then return to IDLE.
  - Non-owner rdata_o and ack_o are unchanged and 0 respectively.
  - rdata_o holds its value until overwritten by the next access of the same side.
- Latency: request seen in IDLE at cycle 0; mem_req_o high at cycle 1; zero-wait memory (ack at cycle 1) gives ack_o at cycle 2. Each memory wait state adds one cycle.
- Requester contract:
  - req must stay high with stable addr/data until ack.
  - req still high in the IDLE cycle after ack is a new, back-to-back transaction.
  - req dropping during BUSY does not cancel the access; it completes and the ack pulses anyway.
- mem_ack_i while not in BUSY is ignored.
- err_o clears only on reset.
- Widths: addresses and data pass through unmodified; no alignment checks.

Test Plan:
- I only, addr 0x00000004, memory returns 0x20080005 with zero wait → mem_req_o at cycle 1 with mem_addr_o=0x4 and mem_we_o=0; i_ack_o=1 at cycle 2 with i_rdata_o=0x20080005; owner_o=0.
- D store addr 0x10 data 0xCAFEBABE, memory acks after 3 wait cycles → mem_we_o=1 and mem_wdata_o=0xCAFEBABE stable for 4 cycles; d_ack_o at cycle 5; d_rdata_o=0.
- I and D requesting continuously, STARVE_LIMIT=4, zero-wait memory → grant sequence D,D,D,D,I,D,D,D,D,I…; each grant takes 3 cycles.
- D load with mem_ack_i never asserted, TIMEOUT=16 → mem_req_o high 16 cycles then low; d_ack_o pulses with d_rdata_o=0; err_o=1 and stays 1 across later good accesses.
- rst_i pulled low during BUSY of an I access → mem_req_o=0 within the same cycle; no i_ack_o; after release, a new d_req is served normally with owner_o=1.
- i_req held high across its ack → second fetch starts in the IDLE cycle right after RESP; two distinct i_ack_o pulses 3 cycles apart with zero-wait memory.
